alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have: rst_i  input  1  synchronous, active-low reset; sampled only on rising edge of clk_i.
REQ-003 The block SHALL have: valid_i  input  1  request strobe; operands and ctrl_i valid this cycle.
REQ-004 The block SHALL have: ctrl_i  input  4  ALU control code from the ALU controller (0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 9 SRA, 11 SRAV, 13 SLTU, 14 LUI).
REQ-005 The block SHALL have: src1_i  input  32  operand A (rs).
REQ-006 The block SHALL have: src2_i  input  32  operand B (rt or sign/zero-extended immediate).
REQ-007 The block SHALL have: shamt_i  input  5  shift amount for SRA.
REQ-008 The block SHALL have: ready_o  output  1  high when a request can be accepted.
REQ-009 The block SHALL have: done_o  output  1  one-cycle pulse; result_o/zero_o/err_o valid.
REQ-010 The block SHALL have: result_o  output  32  registered result.
REQ-011 The block SHALL have: zero_o  output  1  high when result_o == 0 (branch compare).
REQ-012 The block SHALL have: err_o  output  1  high with done_o when ctrl_i was an undefined code.

Function
REQ-013 States SHALL be IDLE, MUL_BUSY, DONE; ready_o SHALL equal (state == IDLE), combinationally.
REQ-014 Accept SHALL occur on a rising edge with state IDLE and valid_i=1; ctrl_i, src1_i, src2_i, shamt_i SHALL be captured at that edge.
REQ-015 valid_i while not IDLE SHALL be ignored; no request queued or dropped-with-side-effect.
REQ-016 Single-cycle codes (all except 3) SHALL go IDLE->DONE; result registered at accept edge; done_o high for the next cycle (latency 1).
REQ-017 AND/OR/ADD/SUB: 32-bit bitwise/two's-complement, carry/overflow discarded, wrap modulo 2^32.
REQ-018 SLT: result 1 if signed(src1) < signed(src2), else 0; SLTU: same, unsigned.
REQ-019 SRA: signed(src2) >>> shamt_i; SRAV: signed(src2) >>> src1[4:0]; shift 0 SHALL return src2 unchanged.
REQ-020 LUI: result = {src2[15:0], 16'h0000}.
REQ-021 MUL: IDLE->MUL_BUSY; iterative shift-add, one multiplier bit per cycle, 5-bit counter 0..31; after 32 cycles in MUL_BUSY go to DONE; done_o in cycle 33 after accept.
REQ-022 MUL result SHALL be low 32 bits of src1*src2 (identical for signed/unsigned); upper bits discarded.
REQ-023 Undefined codes (4,5,8,10,12,15) SHALL complete as single-cycle with result_o=0, zero_o=1, err_o=1.
REQ-024 DONE SHALL last exactly one cycle then return to IDLE; done_o SHALL never be high two consecutive cycles.
REQ-025 result_o, zero_o SHALL hold last completed values until next completion; err_o SHALL clear at next completion without error.
REQ-026 Back-to-back: a request SHALL be acceptable in the IDLE cycle right after DONE (throughput 1 op per 2 cycles for single-cycle ops).
REQ-027 Intermediate MUL partial products SHALL NOT appear on result_o before done_o.

Reset
REQ-028 With rst_i=0 at a rising edge: state=IDLE, counter=0, result_o=0, zero_o=1, done_o=0, err_o=0, ready_o=1 next cycle.
REQ-029 Reset during MUL_BUSY or DONE SHALL abort the operation; no done_o pulse for it after reset release.
REQ-030 valid_i asserted in the same edge as rst_i=0 SHALL NOT be accepted.

Verification
REQ-031 ADD src1=0xFFFFFFFF, src2=1 -> done_o one cycle after accept, result_o=0, zero_o=1, err_o=0.
REQ-032 MUL src1=0xFFFFFFFE (-2), src2=3 -> ready_o low 33 cycles, done_o at cycle 33, result_o=0xFFFFFFFA; valid_i pulsed mid-MUL ignored.
REQ-033 SRA src2=0x80000000, shamt_i=4 -> 0xF8000000; SRAV src1=0x24 (uses 4), same src2 -> 0xF8000000; SLTU src1=1, src2=0xFFFFFFFF -> 1; SLT same -> 0.
REQ-034 LUI src2=0x00001234 -> 0x12340000; ctrl_i=5 -> result_o=0, err_o=1, zero_o=1.
REQ-035 Reset asserted at cycle 10 of MUL -> ready_o=1, result_o=0, no done_o; new SUB 5-7 then yields 0xFFFFFFFE.
REQ-036 Back-to-back OR requests held valid_i=1 continuously -> accepts every second cycle, done_o alternating, results in issue order.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU execute stage with an iterative multiplier.
// Ports: clk_i, rst_i (sync, active-low), valid_i/ctrl_i/src1_i/src2_i/shamt_i
//        request; ready_o, done_o, result_o, zero_o, err_o completion.
module alu_exec_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [3:0]  ctrl_i,
   input  logic [31:0] src1_i,
   input  logic [31:0] src2_i,
   input  logic [4:0]  shamt_i,
   output logic        ready_o,
   output logic        done_o,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DONE     = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd9;
   localparam logic [3:0] OP_SRAV = 4'd11;
   localparam logic [3:0] OP_SLTU = 4'd13;
   localparam logic [3:0] OP_LUI  = 4'd14;

   state_t      state;
   logic [4:0]  cnt;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [31:0] acc;

   logic [31:0] alu_res;
   logic        alu_err;
   logic [31:0] acc_next;

   assign ready_o = (state == IDLE);

   // Shift-add step: consume the low multiplier bit this cycle.
   assign acc_next = acc + (mplier[0] ? mcand : 32'd0);

   // Single-cycle datapath, evaluated on the live request inputs.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      unique case (ctrl_i)
         OP_AND:  alu_res = src1_i & src2_i;
         OP_OR:   alu_res = src1_i | src2_i;
         OP_ADD:  alu_res = src1_i + src2_i;
         OP_MUL:  alu_res = '0;
         OP_SUB:  alu_res = src1_i - src2_i;
         OP_SLT:  alu_res = {31'd0, $signed(src1_i) < $signed(src2_i)};
         OP_SRA:  alu_res = $unsigned($signed(src2_i) >>> shamt_i);
         OP_SRAV: alu_res = $unsigned($signed(src2_i) >>> src1_i[4:0]);
         OP_SLTU: alu_res = {31'd0, src1_i < src2_i};
         OP_LUI:  alu_res = {src2_i[15:0], 16'h0000};
         default: alu_err = 1'b1;
      endcase
   end

   // Control FSM and registered outputs. result_o only changes on
   // completion, so partial products stay internal to acc.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         result_o <= '0;
         zero_o   <= 1'b1;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (valid_i) begin
                  if (ctrl_i == OP_MUL) begin
                     state  <= MUL_BUSY;
                     mcand  <= src1_i;
                     mplier <= src2_i;
                     acc    <= '0;
                     cnt    <= '0;
                  end else begin
                     state    <= DONE;
                     done_o   <= 1'b1;
                     result_o <= alu_res;
                     zero_o   <= (alu_res == 32'd0);
                     err_o    <= alu_err;
                  end
               end
            end
            MUL_BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 5'd1;
               if (cnt == 5'd31) begin
                  state    <= DONE;
                  cnt      <= '0;
                  done_o   <= 1'b1;
                  result_o <= acc_next;
                  zero_o   <= (acc_next == 32'd0);
                  err_o    <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
